// File: rtl/bot_update_intr_pkg.sv
// Shared definitions for the Rojobot update-interrupt block: FSM encoding,
// register-window offsets, status bit positions and the default base address.
// Latency: n/a (definitions only). Backpressure: n/a.
package bot_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [7:0] BASE_ADDR_DEF = 8'h0A;
  localparam int         NUM_SNAP      = 6;

  // Offsets from the base address of the CPU register window.
  localparam logic [7:0] OFF_LOCX    = 8'd0;
  localparam logic [7:0] OFF_LOCY    = 8'd1;
  localparam logic [7:0] OFF_BOTINFO = 8'd2;
  localparam logic [7:0] OFF_SENSORS = 8'd3;
  localparam logic [7:0] OFF_LMDIST  = 8'd4;
  localparam logic [7:0] OFF_RMDIST  = 8'd5;
  localparam logic [7:0] OFF_COUNT   = 8'd6;
  localparam logic [7:0] OFF_STATUS  = 8'd7;
  localparam logic [7:0] OFF_MAX_LO  = 8'd8;
  localparam logic [7:0] OFF_MAX_HI  = 8'd9;

  // Status register bit positions.
  localparam int STAT_INT = 0;
  localparam int STAT_ACK = 1;
  localparam int STAT_SAT = 2;

endpackage

// File: rtl/bot_update_intr_if.sv
// Signal bundle between the Rojobot/CPU environment and bot_update_intr.
// master = environment side (drives flag, live registers, CPU bus);
// slave  = bot_update_intr (drives IO_INT_ACK, interrupt, in_port).
interface bot_update_intr_if;
  logic       IO_BotUpdt_Sync;
  logic       IO_INT_ACK;
  logic [7:0] LocX;
  logic [7:0] LocY;
  logic [7:0] BotInfo;
  logic [7:0] Sensors;
  logic [7:0] LMDist;
  logic [7:0] RMDist;
  logic       interrupt;
  logic       interrupt_ack;
  logic [7:0] port_id;
  logic       read_strobe;
  logic       write_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;

  modport master (
    output IO_BotUpdt_Sync, LocX, LocY, BotInfo, Sensors, LMDist, RMDist,
    output interrupt_ack, port_id, read_strobe, write_strobe, out_port,
    input  IO_INT_ACK, interrupt, in_port
  );

  modport slave (
    input  IO_BotUpdt_Sync, LocX, LocY, BotInfo, Sensors, LMDist, RMDist,
    input  interrupt_ack, port_id, read_strobe, write_strobe, out_port,
    output IO_INT_ACK, interrupt, in_port
  );
endinterface

// File: rtl/bot_update_intr_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
// Latency: count visible one cycle after enable. Backpressure: none.
// Ports: clk, rst (sync, active-high), clr, en -> cnt[W-1:0], sat (cnt is all-ones).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         sat
);

  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/bot_update_intr.sv
// Captures a coherent Rojobot register snapshot on the update flag, raises the
// PicoBlaze interrupt, returns IO_INT_ACK on interrupt_ack, and serves snapshot,
// update count, status and max interrupt latency on the CPU read bus.
// Latency: interrupt/snapshot 1 cycle after flag; in_port 1 cycle after port_id.
// Backpressure: none; flag is held by the synchronizer until IO_INT_ACK clears it.
// Ports: clk50, reset (sync, active-high), bus (bot_update_intr_if.slave).
module bot_update_intr
  import bot_io_pkg::*;
#(
  parameter int         LAT_W     = 16,
  parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input logic              clk50,
  input logic              reset,
  bot_update_intr_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       snap [NUM_SNAP];
  logic [7:0]       upd_cnt;
  logic [LAT_W-1:0] max_lat;
  logic [LAT_W-1:0] cur_lat;
  logic             cur_sat;
  logic             capture;
  logic             ack_take;
  logic             clr_stats;
  logic [7:0]       off;
  logic [15:0]      max_ext;
  logic [7:0]       rd_dat;
  logic             unused_ok;

  // Capture only from IDLE, so a flag still high after the ack is not recounted.
  assign capture   = (state == ST_IDLE) && bus.IO_BotUpdt_Sync;
  assign ack_take  = (state == ST_PEND) && bus.interrupt_ack;
  assign clr_stats = bus.write_strobe && (bus.port_id == (BASE_ADDR + OFF_STATUS));

  // Read data is purely address driven; write data and read strobe carry no meaning here.
  assign unused_ok = ^{bus.out_port, bus.read_strobe, cur_sat};

  // ---------------- FSM ----------------
  always_ff @(posedge clk50) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.IO_BotUpdt_Sync)  state_nxt = ST_PEND;
      ST_PEND: if (bus.interrupt_ack)    state_nxt = ST_ACK;
      ST_ACK:  if (!bus.IO_BotUpdt_Sync) state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.interrupt  = (state == ST_PEND);
    bus.IO_INT_ACK = (state == ST_ACK);
  end

  // ---------------- snapshot ----------------
  always_ff @(posedge clk50) begin
    if (reset) begin
      for (int i = 0; i < NUM_SNAP; i++) snap[i] <= '0;
    end else if (capture) begin
      snap[0] <= bus.LocX;
      snap[1] <= bus.LocY;
      snap[2] <= bus.BotInfo;
      snap[3] <= bus.Sensors;
      snap[4] <= bus.LMDist;
      snap[5] <= bus.RMDist;
    end
  end

  // ---------------- latency / statistics ----------------
  // Cleared on capture, so an ack in the first PEND cycle sees 0.
  sat_counter #(.W(LAT_W)) u_cur_lat (
    .clk (clk50),
    .rst (reset),
    .clr (capture),
    .en  (state == ST_PEND),
    .cnt (cur_lat),
    .sat (cur_sat)
  );

  // CPU clear takes priority over a coinciding ack.
  always_ff @(posedge clk50) begin
    if (reset) begin
      upd_cnt <= '0;
      max_lat <= '0;
    end else if (clr_stats) begin
      upd_cnt <= '0;
      max_lat <= '0;
    end else if (ack_take) begin
      upd_cnt <= upd_cnt + 8'd1;
      if (cur_lat > max_lat) max_lat <= cur_lat;
    end
  end

  // ---------------- read window ----------------
  assign off     = bus.port_id - BASE_ADDR;  // wraps, so addresses below BASE fall outside
  assign max_ext = 16'(max_lat);

  always_comb begin
    rd_dat = 8'h00;
    case (off)
      OFF_LOCX:    rd_dat = snap[0];
      OFF_LOCY:    rd_dat = snap[1];
      OFF_BOTINFO: rd_dat = snap[2];
      OFF_SENSORS: rd_dat = snap[3];
      OFF_LMDIST:  rd_dat = snap[4];
      OFF_RMDIST:  rd_dat = snap[5];
      OFF_COUNT:   rd_dat = upd_cnt;
      OFF_STATUS: begin
        rd_dat[STAT_INT] = bus.interrupt;
        rd_dat[STAT_ACK] = (state == ST_ACK);
        rd_dat[STAT_SAT] = &max_lat;
      end
      OFF_MAX_LO:  rd_dat = max_ext[7:0];
      OFF_MAX_HI:  rd_dat = max_ext[15:8];
      default:     rd_dat = 8'h00;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      bus.in_port <= 8'h00;
    end else begin
      bus.in_port <= rd_dat;
    end
  end

endmodule

// File: tb/tb_bot_update_intr.sv
// Randomized scoreboard bench for bot_update_intr: reads push expected values
// from a behavioural model; a monitor pops and compares one cycle later.
module tb_bot_update_intr;
  import bot_io_pkg::*;

  localparam int         LAT_W   = 6;
  localparam int         LAT_MAX = (1 << LAT_W) - 1;
  localparam logic [7:0] BASE    = 8'h0A;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] val;
  } rd_exp_t;

  logic clk50 = 1'b0;
  logic reset;

  bot_update_intr_if bus();

  bot_update_intr #(.LAT_W(LAT_W), .BASE_ADDR(BASE)) dut (
    .clk50 (clk50),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk50 = ~clk50;

  int      n_chk  = 0;
  int      n_fail = 0;
  rd_exp_t exp_q[$];

  // Behavioural model state
  logic [7:0] m_snap [6];
  int         m_count;
  int         m_max;
  bit         m_int;
  bit         m_ack;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_bit(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_read(logic [7:0] addr);
    logic [7:0] off;
    off = addr - BASE;
    if (off < 8'd6) return m_snap[int'(off)];
    case (off)
      8'd6:    return m_count[7:0];
      8'd7:    return {5'b0, (m_max == LAT_MAX), m_ack, m_int};
      8'd8:    return m_max[7:0];
      8'd9:    return m_max[15:8];
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_snap[i] = 8'h00;
    m_count = 0;
    m_max   = 0;
    m_int   = 0;
    m_ack   = 0;
  endtask

  task automatic set_regs(logic [47:0] v);
    bus.LocX    = v[47:40];
    bus.LocY    = v[39:32];
    bus.BotInfo = v[31:24];
    bus.Sensors = v[23:16];
    bus.LMDist  = v[15:8];
    bus.RMDist  = v[7:0];
  endtask

  function automatic logic [47:0] rand48();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom();
    b = $urandom();
    return {a, b[15:0]};
  endfunction

  // All stimulus tasks start and end just after a falling edge.
  task automatic do_read(logic [7:0] addr);
    rd_exp_t e;
    bus.port_id     = addr;
    bus.read_strobe = 1'b1;
    e.addr = addr;
    e.val  = model_read(addr);
    exp_q.push_back(e);
    @(negedge clk50);
    bus.read_strobe = 1'b0;
  endtask

  task automatic do_clear();
    bus.port_id      = BASE + 8'd7;
    bus.write_strobe = 1'b1;
    bus.out_port     = 8'($urandom());
    @(negedge clk50);
    bus.write_strobe = 1'b0;
    m_count = 0;
    m_max   = 0;
  endtask

  task automatic start_update(logic [47:0] v);
    set_regs(v);
    bus.IO_BotUpdt_Sync = 1'b1;
    @(negedge clk50);
    for (int i = 0; i < 6; i++) m_snap[i] = v[47-8*i -: 8];
    m_int = 1;
    chk_bit("int_rise", bus.interrupt, 1'b1);
    chk_bit("ack_low_in_pend", bus.IO_INT_ACK, 1'b0);
  endtask

  // pre: PEND cycles already spent by the caller; d: extra wait; h: cycles the
  // flag stays high after IO_INT_ACK rises; clr: CPU clear on the ack edge.
  task automatic finish_update(int pre, int d, int h, bit clr);
    int lat;
    for (int i = 0; i < d; i++) begin
      set_regs(rand48());
      @(negedge clk50);
      chk_bit("int_held", bus.interrupt, 1'b1);
    end
    bus.interrupt_ack = 1'b1;
    if (clr) begin
      bus.port_id      = BASE + 8'd7;
      bus.write_strobe = 1'b1;
      bus.out_port     = 8'($urandom());
    end
    @(negedge clk50);
    bus.interrupt_ack = 1'b0;
    bus.write_strobe  = 1'b0;
    lat = (pre + d > LAT_MAX) ? LAT_MAX : pre + d;
    m_count = (m_count + 1) % 256;
    if (lat > m_max) m_max = lat;
    if (clr) begin
      m_count = 0;
      m_max   = 0;
    end
    m_int = 0;
    m_ack = 1;
    chk_bit("int_fall", bus.interrupt, 1'b0);
    chk_bit("int_ack_rise", bus.IO_INT_ACK, 1'b1);
    for (int i = 0; i < h; i++) begin
      if (i == 0) do_read(BASE + 8'd7);
      else        @(negedge clk50);
      chk_bit("int_ack_hold", bus.IO_INT_ACK, 1'b1);
    end
    bus.IO_BotUpdt_Sync = 1'b0;
    @(negedge clk50);
    m_ack = 0;
    chk_bit("int_ack_fall", bus.IO_INT_ACK, 1'b0);
    chk_bit("int_stays_low", bus.interrupt, 1'b0);
    @(negedge clk50);
    chk_bit("no_reint", bus.interrupt, 1'b0);
  endtask

  // Monitor: any read sampled on a rising edge is checked on the next falling edge.
  initial begin : monitor
    bit      rd_s;
    rd_exp_t e;
    forever begin
      @(posedge clk50);
      rd_s = bus.read_strobe;
      @(negedge clk50);
      if (rd_s) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_unexpected: got %02h expected no read", bus.in_port);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("rd@%02h", e.addr), bus.in_port, e.val);
        end
      end
    end
  end

  initial begin : watchdog
    #(10_000_000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [47:0] v;
    reset                = 1'b1;
    bus.IO_BotUpdt_Sync  = 1'b0;
    bus.interrupt_ack    = 1'b0;
    bus.port_id          = 8'h00;
    bus.read_strobe      = 1'b0;
    bus.write_strobe     = 1'b0;
    bus.out_port         = 8'h00;
    set_regs(48'h0);
    model_reset();

    repeat (3) @(negedge clk50);
    chk_bit("rst_interrupt", bus.interrupt, 1'b0);
    chk_bit("rst_int_ack", bus.IO_INT_ACK, 1'b0);
    chk("rst_in_port", bus.in_port, 8'h00);
    reset = 1'b0;

    // Whole window at reset, plus addresses just outside it.
    for (int a = 0; a < 10; a++) do_read(BASE + 8'(a));
    do_read(8'h09);
    do_read(8'h14);
    do_read(8'hFF);

    // First update; live inputs change during PEND; ack at latency 5.
    start_update(48'h12_34_56_78_9A_3C);
    do_read(BASE + 8'd0);
    do_read(BASE + 8'd5);
    bus.LocX = 8'h99;
    do_read(BASE + 8'd0);
    do_read(BASE + 8'd7);
    finish_update(4, 1, 0, 1'b0);
    do_read(BASE + 8'd6);
    do_read(BASE + 8'd8);
    do_read(BASE + 8'd9);
    do_read(BASE + 8'd7);

    // interrupt_ack in IDLE is ignored.
    bus.interrupt_ack = 1'b1;
    @(negedge clk50);
    bus.interrupt_ack = 1'b0;
    chk_bit("stray_ack_int", bus.interrupt, 1'b0);
    chk_bit("stray_ack_intack", bus.IO_INT_ACK, 1'b0);
    do_read(BASE + 8'd6);

    // Flag held 3 cycles after IO_INT_ACK: a single count.
    start_update(rand48());
    finish_update(0, 2, 3, 1'b0);
    do_read(BASE + 8'd6);
    do_read(BASE + 8'd8);

    // Remaining 254 updates make 256 in total: count wraps to 00.
    for (int i = 0; i < 254; i++) begin
      start_update(rand48());
      finish_update(0, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      do_read(BASE + 8'($urandom_range(0, 9)));
    end
    do_read(BASE + 8'd6);
    do_read(8'($urandom_range(0, 255)));

    // CPU clear of count and max-latency.
    start_update(rand48());
    finish_update(0, 4, 1, 1'b0);
    do_read(BASE + 8'd6);
    do_clear();
    do_read(BASE + 8'd6);
    do_read(BASE + 8'd8);
    do_read(BASE + 8'd9);

    // Clear on the same edge as the ack: clear wins.
    start_update(rand48());
    finish_update(0, 3, 1, 1'b1);
    do_read(BASE + 8'd6);
    do_read(BASE + 8'd8);

    // Latency saturation.
    start_update(rand48());
    finish_update(0, 70, 0, 1'b0);
    do_read(BASE + 8'd7);
    do_read(BASE + 8'd8);
    do_read(BASE + 8'd9);

    // Reset while PEND with the flag still high, then re-capture.
    start_update(rand48());
    reset = 1'b1;
    @(negedge clk50);
    chk_bit("midrst_interrupt", bus.interrupt, 1'b0);
    chk_bit("midrst_int_ack", bus.IO_INT_ACK, 1'b0);
    chk("midrst_in_port", bus.in_port, 8'h00);
    model_reset();
    v = rand48();
    set_regs(v);
    reset = 1'b0;
    @(negedge clk50);
    for (int i = 0; i < 6; i++) m_snap[i] = v[47-8*i -: 8];
    m_int = 1;
    chk_bit("recapture_int", bus.interrupt, 1'b1);
    do_read(BASE + 8'd0);
    do_read(BASE + 8'd5);
    finish_update(2, 1, 0, 1'b0);
    do_read(BASE + 8'd6);
    do_read(BASE + 8'd8);
    do_read(BASE + 8'd3);

    repeat (3) @(negedge clk50);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
